input_event_fifo: RTL and testbench
===================================

INPUT_EVENT_FIFO -- requirements
Module: input_event_fifo

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, number of input event channels (1..4; ch0 = PS/2 keyboard).
REQ-002 The block SHALL have parameter CODE_W, default 8, scan/event code width.
REQ-003 The block SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >= 2).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1, sole clock.
REQ-006 The block SHALL have port reset_i, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port code_i, input, NUM_CH*CODE_W, per-channel code (channel c at bits [c*CODE_W +: CODE_W]).
REQ-008 The block SHALL have port strobe_i, input, NUM_CH, one-cycle code-valid pulse per channel.
REQ-009 The block SHALL have port err_i, input, NUM_CH, per-channel error qualifier, sampled only with strobe_i.
REQ-010 The block SHALL have port clear_i, input, 1, synchronous flush.
REQ-011 The block SHALL have port rd_valid_o, output, 1, head entry available.
REQ-012 The block SHALL have port rd_ready_i, input, 1, consumer accepts head.
REQ-013 The block SHALL have ports rd_code_o (output, CODE_W), rd_ch_o (output, CH_W = max(1, clog2(NUM_CH))) and rd_err_o (output, 1), head entry fields.
REQ-014 The block SHALL have port level_o, output, clog2(DEPTH)+1, FIFO occupancy.
REQ-015 The block SHALL have ports overflow_o (output, 1, sticky drop flag) and drop_count_o (output, 8, saturating drop count).

Function
REQ-016 Each channel SHALL have a one-entry holding register {valid, code, err}; a strobe_i[c] at edge E0 loads it.
REQ-017 A round-robin arbiter SHALL grant at most one valid holding register per cycle, starting after the last granted channel, and write it to the FIFO as {code, ch, err}.
REQ-018 A write SHALL occur only when the FIFO is not full, or when a pop occurs in the same cycle; otherwise holding registers retain their contents.
REQ-019 Latency SHALL be as follows: strobe in cycle N, FIFO empty, no contention -> rd_valid_o high in cycle N+2 with that entry at the head.
REQ-020 The FIFO SHALL be show-ahead; a pop occurs on an edge where rd_valid_o && rd_ready_i; rd_* outputs are undefined while rd_valid_o is low.
REQ-021 A strobe on a channel whose holding register is valid and not granted in that cycle SHALL be dropped (the older entry is kept), set overflow_o, and increment drop_count_o, saturating at 255.
REQ-022 A strobe on a channel whose holding register is granted in the same cycle SHALL be accepted with no drop.
REQ-023 Simultaneous drops on k channels SHALL add k to drop_count_o, saturating.
REQ-024 level_o SHALL be unchanged on a simultaneous write and pop, and the read and write pointers SHALL wrap modulo DEPTH.
REQ-025 clear_i SHALL empty the FIFO and holding registers and zero overflow_o and drop_count_o; strobes in the clear cycle SHALL be discarded without counting; clear_i SHALL take priority over all other events.
REQ-026 The arbiter SHALL preserve per-channel ordering; entries from one channel SHALL never be reordered.

Reset
REQ-027 During reset, rd_valid_o SHALL be 0, level_o 0, overflow_o 0, drop_count_o 0, all holding registers invalid, pointers 0, and the arbiter pointer at ch0.
REQ-028 Reset assertion mid-operation SHALL discard all pending and stored events immediately, with no partial entry visible after deassertion.

Structure
REQ-029 Package input_event_pkg SHALL hold the entry struct typedef (code, ch, err), the DROP_CNT_W=8 constant and the CH_W width function.
REQ-030 Storage SHALL be a sub-module sync_fifo (parametrised width/depth, show-ahead, level output); arbitration and holding registers SHALL reside in input_event_fifo.

Verification
REQ-031 The bench SHALL cover: single strobe ch0 code 0x1C, rd_ready_i=1 -> rd_valid_o high 2 cycles later, rd_code_o=0x1C, rd_ch_o=0, rd_err_o=0, level_o back to 0.
REQ-032 The bench SHALL cover: ch0 0x12 and ch1 0x34 strobed in the same cycle -> two entries, order ch0 then ch1; next simultaneous pair -> ch1 first (round-robin).
REQ-033 The bench SHALL cover: rd_ready_i=0, 17 strobes on ch0 at DEPTH=16 -> level_o=16, holding register keeps entry 17, and a further strobe raises overflow_o with drop_count_o=1.
REQ-034 The bench SHALL cover: 300 drops -> drop_count_o=255; then clear_i -> level_o=0, overflow_o=0, drop_count_o=0, rd_valid_o=0.
REQ-035 The bench SHALL cover: full FIFO with pop and pending holding entry in the same cycle -> level_o stays 16 and the entry is written.
REQ-036 The bench SHALL cover: strobe with err_i=1 code 0xFF, then reset asserted mid-stream -> after reset all outputs are at reset values; a prior read, if any, shows rd_err_o=1.

Source files
------------

// File: rtl/input_event_pkg.sv
// Shared types and sizing helpers for the input event FIFO.
// Channel codes are carried in a fixed-width entry so the struct does not depend on instance parameters.
package input_event_pkg;
  localparam int DROP_CNT_W = 8;
  localparam int CODE_W_MAX = 16;
  localparam int CH_W_MAX   = 2;

  typedef struct packed {
    logic [CODE_W_MAX-1:0] code;
    logic [CH_W_MAX-1:0]   ch;
    logic                  err;
  } entry_t;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output and synchronous flush.
// A push is accepted on a full FIFO only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [WIDTH-1:0] dout_o,
  output logic [AW:0]      level_o
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_level;
  logic             w_push, w_pop;

  assign valid_o = (r_level != '0);
  assign full_o  = (r_level == (AW+1)'(DEPTH));
  assign w_pop   = pop_i && valid_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign dout_o  = r_mem[r_rptr];
  assign level_o = r_level;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array carries no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push && !clear_i) r_mem[r_wptr] <= din_i;
  end
endmodule

// File: rtl/input_event_fifo.sv
// Multi-channel input event collector: per-channel holding registers, round-robin
// arbitration into a show-ahead FIFO, with sticky overflow and saturating drop count.
module input_event_fifo
  import input_event_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CODE_W  = 8,
  parameter int DEPTH   = 16,
  localparam int CH_W   = ch_w(NUM_CH),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic [NUM_CH*CODE_W-1:0] code_i,
  input  logic [NUM_CH-1:0]        strobe_i,
  input  logic [NUM_CH-1:0]        err_i,
  input  logic                     clear_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [CODE_W-1:0]        rd_code_o,
  output logic [CH_W-1:0]          rd_ch_o,
  output logic                     rd_err_o,
  output logic [LVL_W-1:0]         level_o,
  output logic                     overflow_o,
  output logic [DROP_CNT_W-1:0]    drop_count_o
);
  logic [NUM_CH-1:0]             r_hv, r_herr;
  logic [NUM_CH-1:0][CODE_W-1:0] r_hcode;
  logic [CH_W-1:0]               r_rr_ptr;
  logic                          r_ovf;
  logic [DROP_CNT_W-1:0]         r_cnt;

  logic                  w_full, w_pop, w_can_wr;
  logic                  w_gnt_vld;
  logic [CH_W-1:0]       w_gnt_idx;
  logic [NUM_CH-1:0]     w_gnt_one, w_drop;
  logic [3:0]            w_ndrop;
  logic [DROP_CNT_W:0]   w_cnt_sum;
  entry_t                w_ent, w_head;
  logic                  w_unused_head;

  assign w_pop    = rd_valid_o && rd_ready_i;
  assign w_can_wr = !w_full || w_pop;

  // Rotating search starting at r_rr_ptr, the channel after the last grant.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] cidx;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cidx = CH_W'(idx);
      if (!w_gnt_vld && r_hv[cidx] && w_can_wr && !clear_i) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = cidx;
      end
    end
  end

  always_comb begin
    w_ndrop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_gnt_one[c] = w_gnt_vld && (w_gnt_idx == CH_W'(c));
      w_drop[c]    = strobe_i[c] && r_hv[c] && !w_gnt_one[c] && !clear_i;
      w_ndrop      = w_ndrop + 4'(w_drop[c]);
    end
  end

  assign w_cnt_sum = {1'b0, r_cnt} + (DROP_CNT_W+1)'(w_ndrop);

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_hv    <= '0;
      r_herr  <= '0;
      r_hcode <= '0;
    end else if (clear_i) begin
      r_hv <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // A slot being granted this cycle can take a new code without a drop.
        if (strobe_i[c] && (!r_hv[c] || w_gnt_one[c])) begin
          r_hv[c]    <= 1'b1;
          r_hcode[c] <= code_i[c*CODE_W +: CODE_W];
          r_herr[c]  <= err_i[c];
        end else if (w_gnt_one[c]) begin
          r_hv[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_rr_ptr <= (w_gnt_idx == CH_W'(NUM_CH-1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (clear_i) begin
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (|w_drop) begin
      r_ovf <= 1'b1;
      r_cnt <= w_cnt_sum[DROP_CNT_W] ? '1 : w_cnt_sum[DROP_CNT_W-1:0];
    end
  end

  always_comb begin
    w_ent      = '0;
    w_ent.code = CODE_W_MAX'(r_hcode[w_gnt_idx]);
    w_ent.ch   = CH_W_MAX'(w_gnt_idx);
    w_ent.err  = r_herr[w_gnt_idx];
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .push_i  (w_gnt_vld),
    .din_i   (w_ent),
    .pop_i   (w_pop),
    .valid_o (rd_valid_o),
    .full_o  (w_full),
    .dout_o  (w_head),
    .level_o (level_o)
  );

  assign rd_code_o     = w_head.code[CODE_W-1:0];
  assign rd_ch_o       = w_head.ch[CH_W-1:0];
  assign rd_err_o      = w_head.err;
  assign w_unused_head = &{1'b0, w_head};
  assign overflow_o    = r_ovf;
  assign drop_count_o  = r_cnt;
endmodule

// File: tb/tb_input_event_fifo.sv
// Directed bench for input_event_fifo at NUM_CH=2, CODE_W=8, DEPTH=16.
module tb_input_event_fifo;
  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] code_i;
  logic [1:0]  strobe_i, err_i;
  logic        clear_i, rd_ready_i;
  logic        rd_valid_o, rd_ch_o, rd_err_o, overflow_o;
  logic [7:0]  rd_code_o, drop_count_o;
  logic [4:0]  level_o;
  int          tests = 0;
  int          fails = 0;

  input_event_fifo #(.NUM_CH(2), .CODE_W(8), .DEPTH(16)) dut (
    .clk(clk), .reset_i(reset_i), .code_i(code_i), .strobe_i(strobe_i), .err_i(err_i),
    .clear_i(clear_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_code_o(rd_code_o), .rd_ch_o(rd_ch_o), .rd_err_o(rd_err_o), .level_o(level_o),
    .overflow_o(overflow_o), .drop_count_o(drop_count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stb(input int ch, input logic [7:0] code, input logic err);
    strobe_i[ch]         = 1'b1;
    code_i[ch*8 +: 8]    = code;
    err_i[ch]            = err;
  endtask

  task automatic idle();
    strobe_i = '0;
    err_i    = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(rd_valid_o), 0);
    chk({tag, "_level"}, 32'(level_o), 0);
    chk({tag, "_ovf"},   32'(overflow_o), 0);
    chk({tag, "_cnt"},   32'(drop_count_o), 0);
  endtask

  task automatic fill17();
    for (int k = 1; k <= 17; k++) begin
      stb(0, 8'(k), 1'b0);
      step();
    end
    idle();
    step();
  endtask

  initial begin
    reset_i = 1'b0; code_i = '0; strobe_i = '0; err_i = '0; clear_i = 1'b0; rd_ready_i = 1'b0;
    step(); step();
    chk_reset_state("rst");
    reset_i = 1'b1;

    // First simultaneous pair after reset: ch0 before ch1.
    stb(0, 8'h12, 1'b0); stb(1, 8'h34, 1'b0);
    step(); idle(); step(); step();
    chk("pair1_level", 32'(level_o), 2);
    chk("pair1_h0_code", 32'(rd_code_o), 32'h12);
    chk("pair1_h0_ch", 32'(rd_ch_o), 0);
    rd_ready_i = 1'b1; step();
    chk("pair1_h1_code", 32'(rd_code_o), 32'h34);
    chk("pair1_h1_ch", 32'(rd_ch_o), 1);
    step();
    chk("pair1_drained", 32'(level_o), 0);

    // Single strobe latency: visible two cycles after the strobe.
    stb(0, 8'h1C, 1'b0); step(); idle();
    chk("lat_n1_valid", 32'(rd_valid_o), 0);
    step();
    chk("lat_n2_valid", 32'(rd_valid_o), 1);
    chk("lat_code", 32'(rd_code_o), 32'h1C);
    chk("lat_ch", 32'(rd_ch_o), 0);
    chk("lat_err", 32'(rd_err_o), 0);
    chk("lat_level1", 32'(level_o), 1);
    step();
    chk("lat_level0", 32'(level_o), 0);
    chk("lat_valid0", 32'(rd_valid_o), 0);

    // Last grant was ch0, so the next pair starts at ch1.
    rd_ready_i = 1'b0;
    stb(0, 8'h56, 1'b0); stb(1, 8'h78, 1'b0);
    step(); idle(); step(); step();
    chk("pair2_level", 32'(level_o), 2);
    chk("pair2_h0_code", 32'(rd_code_o), 32'h78);
    chk("pair2_h0_ch", 32'(rd_ch_o), 1);
    rd_ready_i = 1'b1; step();
    chk("pair2_h1_code", 32'(rd_code_o), 32'h56);
    chk("pair2_h1_ch", 32'(rd_ch_o), 0);
    step();
    chk("pair2_drained", 32'(level_o), 0);

    // Fill: 16 in FIFO, entry 17 parked; one more strobe drops.
    rd_ready_i = 1'b0;
    fill17();
    chk("full_level", 32'(level_o), 16);
    chk("full_head", 32'(rd_code_o), 1);
    chk("full_ovf0", 32'(overflow_o), 0);
    stb(0, 8'hAA, 1'b0); step(); idle();
    chk("drop1_ovf", 32'(overflow_o), 1);
    chk("drop1_cnt", 32'(drop_count_o), 1);
    chk("drop1_level", 32'(level_o), 16);

    // Pop while full: parked entry 17 enters in the same cycle.
    rd_ready_i = 1'b1; step(); rd_ready_i = 1'b0;
    chk("popfull_level", 32'(level_o), 16);
    chk("popfull_head", 32'(rd_code_o), 2);
    rd_ready_i = 1'b1;
    for (int k = 2; k <= 17; k++) begin
      chk($sformatf("drain_%0d", k), 32'(rd_code_o), 32'(k));
      step();
    end
    rd_ready_i = 1'b0;
    chk("drain_level", 32'(level_o), 0);

    // Saturating drop counter with multi-channel drops, then clear.
    clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("clr1_cnt", 32'(drop_count_o), 0);
    chk("clr1_ovf", 32'(overflow_o), 0);
    fill17();
    stb(1, 8'h99, 1'b0); step(); idle();
    chk("ch1_park_cnt", 32'(drop_count_o), 0);
    stb(0, 8'h01, 1'b0); stb(1, 8'h02, 1'b0); step(); idle();
    chk("dual_drop_cnt", 32'(drop_count_o), 2);
    for (int k = 0; k < 251; k++) begin
      stb(0, 8'h03, 1'b0); step();
    end
    idle();
    chk("cnt_253", 32'(drop_count_o), 253);
    stb(0, 8'h04, 1'b0); stb(1, 8'h05, 1'b0); step();
    chk("cnt_255", 32'(drop_count_o), 255);
    step();
    chk("cnt_sat_dual", 32'(drop_count_o), 255);
    idle();
    for (int k = 0; k < 45; k++) begin
      stb(0, 8'h06, 1'b0); step();
    end
    idle();
    chk("cnt_sat", 32'(drop_count_o), 255);
    chk("ovf_sticky", 32'(overflow_o), 1);
    clear_i = 1'b1; stb(0, 8'h07, 1'b0); stb(1, 8'h08, 1'b0);
    step(); clear_i = 1'b0; idle();
    chk_reset_state("clr2");
    step(); step();
    chk("clr2_no_strobe", 32'(rd_valid_o), 0);

    // Error-qualified entry, then reset mid-stream.
    stb(1, 8'hFF, 1'b1); step(); idle(); step();
    chk("err_valid", 32'(rd_valid_o), 1);
    chk("err_code", 32'(rd_code_o), 32'hFF);
    chk("err_ch", 32'(rd_ch_o), 1);
    chk("err_flag", 32'(rd_err_o), 1);
    rd_ready_i = 1'b1; step(); rd_ready_i = 1'b0;
    stb(0, 8'h11, 1'b0); stb(1, 8'h22, 1'b0); step(); idle();
    reset_i = 1'b0; #1;
    chk_reset_state("midrst");
    step(); reset_i = 1'b1; step(); step(); step();
    chk_reset_state("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
